// File: rtl/auth_cmd_rx.sv
// auth_cmd_rx: 8N1 UART receiver that decodes GO/STOP command bytes for the Auth block
module auth_cmd_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = 1302,
  parameter logic [7:0] CMD_GO = 8'h47,
  parameter logic [7:0] CMD_STOP = 8'h53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       go,
  output logic       stop,
  output logic       frm_err
);
  localparam int CW = $clog2((BAUD_DIV > HALF_DIV ? BAUD_DIV : HALF_DIV) + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic rx_m, rx_s, armed, tick, ld_half, ld_baud, do_shift, accept, ferr;
  logic [CW-1:0] cnt;
  logic [3:0] bcnt;
  logic [7:0] shift;
  // counter is loaded with N and expires at 1, giving exactly N clocks per interval
  assign tick = cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (armed && !rx_s) state_nx = START;
      START: if (tick) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (tick && bcnt == 4'd7) state_nx = STOP;
      STOP:  if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    ld_half = state == IDLE && armed && !rx_s;
    ld_baud = tick && ((state == START && !rx_s) || state == DATA);
    do_shift = tick && state == DATA;
    accept = tick && state == STOP && rx_s;
    ferr = tick && state == STOP && !rx_s;
  end
  // armed only rises after the line is seen high in IDLE, so a held-low line cannot re-trigger
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      armed <= 1'b0;
      cnt <= '0;
      bcnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rdy <= 1'b0;
      go <= 1'b0;
      stop <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      armed <= state == IDLE && rx_s;
      cnt <= ld_half ? CW'(HALF_DIV) : ld_baud ? CW'(BAUD_DIV) : cnt - CW'(cnt != '0);
      bcnt <= state == START ? 4'd0 : do_shift ? bcnt + 4'd1 : bcnt;
      shift <= do_shift ? {rx_s, shift[7:1]} : shift;
      rx_data <= accept ? shift : rx_data;
      rdy <= accept || (rdy && !clr_rdy && !ld_half);
      go <= accept && shift == CMD_GO;
      stop <= accept && shift == CMD_STOP;
      frm_err <= ferr;
    end
endmodule

// File: tb/tb_auth_cmd_rx.sv
// tb_auth_cmd_rx: table-driven scoreboard bench for auth_cmd_rx, plus a default-parameter latency run
module tb_auth_cmd_rx;
  localparam int B = 16, H = 8, BD = 2604, HD = 1302;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_d = 1'b1, clr_rdy = 1'b0;
  logic [7:0] rx_data, rx_data_d;
  logic rdy, go, stop, frm_err, rdy_d, go_d, stop_d, frm_err_d;
  logic rdy_p = 1'b0, go_p = 1'b0, stop_p = 1'b0;
  int checks = 0, fails = 0, nev = 0;
  typedef struct packed {logic [7:0] rd; logic rdy, go, stop, ferr;} exp_t;
  typedef struct {logic [7:0] d; logic sb, clr; exp_t e;} vec_t;
  exp_t q[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  auth_cmd_rx #(.BAUD_DIV(B), .HALF_DIV(H)) dut (.clk(clk), .rst_n(rst_n), .RX(rx), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .go(go), .stop(stop), .frm_err(frm_err));
  auth_cmd_rx dut_d (.clk(clk), .rst_n(rst_n), .RX(rx_d), .clr_rdy(1'b0),
    .rx_data(rx_data_d), .rdy(rdy_d), .go(go_d), .stop(stop_d), .frm_err(frm_err_d));
  // every accepted byte or framing error must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (frm_err || (rdy && !rdy_p)) begin
        exp_t e;
        nev++;
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL spurious_event: rx_data=%h rdy=%b go=%b stop=%b frm_err=%b, none expected", rx_data, rdy, go, stop, frm_err);
        end else begin
          e = q.pop_front();
          if ({rx_data, rdy, go, stop, frm_err} !== e) begin
            fails++;
            $display("FAIL event: got rx_data=%h rdy=%b go=%b stop=%b frm_err=%b, want %h %b %b %b %b",
              rx_data, rdy, go, stop, frm_err, e.rd, e.rdy, e.go, e.stop, e.ferr);
          end
        end
      end
      if (go || stop || go_p || stop_p) begin
        checks++;
        if ((go && stop) || (go && go_p) || (stop && stop_p)) begin
          fails++;
          $display("FAIL pulse_shape: go=%b stop=%b prev go=%b stop=%b, want single exclusive pulses", go, stop, go_p, stop_p);
        end
      end
    end
    rdy_p = rdy;
    go_p = go;
    stop_p = stop;
  end
  task automatic send(input logic [7:0] d, input logic sb, input int div, input bit line, input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = i == 0 ? 1'b0 : i == 9 ? sb : d[i-1];
      if (line) rx_d = b;
      else rx = b;
      repeat (div) @(posedge clk);
      #1;
    end
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50 * B) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d expected events never seen, want 0", q.size());
      q.delete();
    end
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  initial begin
    int n, n0;
    tbl[0] = '{8'h47, 1'b1, 1'b0, '{8'h47, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{8'h53, 1'b1, 1'b0, '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{8'hA5, 1'b1, 1'b0, '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{8'h47, 1'b0, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{8'h00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{8'h53, 1'b1, 1'b0, '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0}};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rx_data, rdy, go, stop, frm_err, rx_data_d, rdy_d, go_d, stop_d, frm_err_d}, 32'h0);
    rst_n = 1'b1;
    idle(4);
    fork
      send(8'h47, 1'b1, BD, 1'b1, 10);
      begin
        n = 0;
        while (!rdy_d && n < 30000) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("default_latency_ok", 32'(n >= HD + 9 * BD + 2 && n <= HD + 9 * BD + 4), 32'h1);
        check("default_go_frame", {rx_data_d, rdy_d, go_d, stop_d}, {8'h47, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        check("default_go_width", {go_d, stop_d}, 32'h0);
      end
    join
    foreach (tbl[i]) begin
      clr_rdy = tbl[i].clr;
      q.push_back(tbl[i].e);
      send(tbl[i].d, tbl[i].sb, B, 1'b0, 10);
      idle(2 * B);
      drain();
      check("rdy_settled", rdy, tbl[i].e.rdy & ~tbl[i].clr);
      clr_rdy = 1'b0;
    end
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy = 1'b0;
    check("clr_rdy_clears", {rx_data, rdy}, {8'h53, 1'b0});
    n0 = nev;
    q.push_back('{8'h53, 1'b0, 1'b0, 1'b0, 1'b1});
    send(8'h47, 1'b0, B, 1'b0, 10);
    repeat (4 * B) @(posedge clk);
    #1;
    check("held_low_no_rearm", nev, n0 + 1);
    drain();
    idle(2 * B);
    q.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0});
    send(8'hA5, 1'b1, B, 1'b0, 10);
    idle(2 * B);
    drain();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy = 1'b0;
    n0 = nev;
    rx = 1'b0;
    repeat (H / 2) @(posedge clk);
    #1;
    idle(3 * B);
    check("glitch_no_event", nev, n0);
    check("glitch_quiet", {rx_data, rdy, go, stop, frm_err}, {8'hA5, 4'h0});
    send(8'h47, 1'b1, B, 1'b0, 5);
    rst_n = 1'b0;
    #2;
    check("midframe_reset", {rx_data, rdy, go, stop, frm_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    rst_n = 1'b1;
    idle(2 * B);
    q.push_back('{8'h53, 1'b1, 1'b0, 1'b1, 1'b0});
    send(8'h53, 1'b1, B, 1'b0, 10);
    idle(2 * B);
    drain();
    check("after_reset_frame", {rx_data, go, stop}, {8'h53, 2'b00});
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/auth_cmd_rx.md
AUTH_CMD_RX -- requirements
Module: auth_cmd_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, SHALL be the clocks per bit (19200 baud at 50 MHz).
REQ-002 Parameter HALF_DIV, default 1302, SHALL be the clocks from the start-bit falling edge to the start-bit mid-sample.
REQ-003 Parameter CMD_GO, default 8'h47 ('G'), SHALL be the authorize command code.
REQ-004 Parameter CMD_STOP, default 8'h53 ('S'), SHALL be the stop command code.
REQ-005 Port clk  input  1  SHALL be the system clock; it is the only clock.
REQ-006 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-007 Port RX  input  1  SHALL be the asynchronous serial line from the BLE module (idle high, 8N1, LSB first).
REQ-008 Port clr_rdy  input  1  SHALL be the consumer acknowledge, which clears rdy.
REQ-009 Port rx_data  output  8  SHALL be the last correctly framed byte.
REQ-010 Port rdy  output  1  SHALL flag that rx_data holds an unconsumed byte.
REQ-011 Port go  output  1  SHALL be a one-clock pulse on acceptance of CMD_GO, feeding the Auth block.
REQ-012 Port stop  output  1  SHALL be a one-clock pulse on acceptance of CMD_STOP, feeding the Auth block.
REQ-013 Port frm_err  output  1  SHALL be a one-clock pulse when the stop bit samples 0.

Function
REQ-014 RX SHALL pass through a two-flop synchronizer, both flops preset to 1; all logic uses only the synchronized value rx_s.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP, plus a baud down-counter and a 4-bit bit counter.
REQ-016 IDLE: rx_s==0 SHALL load the baud counter with HALF_DIV, clear rdy, and enter START.
REQ-017 START: on counter expiry, rx_s==0 SHALL load BAUD_DIV, clear the bit count and enter DATA; rx_s==1 (glitch) SHALL return to IDLE with no output activity.
REQ-018 DATA: each expiry SHALL shift rx_s into shift[7] (right shift, LSB first), reload BAUD_DIV and increment the bit count; after the 8th sample the FSM SHALL enter STOP.
REQ-019 STOP: on expiry with rx_s==1, the FSM SHALL load rx_data from shift, set rdy, and pulse go or stop on the next clock if the byte equals CMD_GO or CMD_STOP; it then enters IDLE.
REQ-020 STOP: on expiry with rx_s==0, the FSM SHALL pulse frm_err for one clock and enter IDLE; rx_data, rdy, go and stop are unchanged.
REQ-021 Latency SHALL be rdy/go/stop asserting HALF_DIV + 9*BAUD_DIV + 3 clocks (±1) after the RX falling edge; 24,741 clocks at the defaults.
REQ-022 rdy SHALL clear on clr_rdy or on a new start edge (REQ-016); if set and clear coincide, set SHALL win.
REQ-023 go and stop SHALL never both be high, and SHALL never be high for more than one consecutive clock.
REQ-024 A byte other than CMD_GO and CMD_STOP SHALL set rdy and update rx_data without pulsing go or stop.
REQ-025 In IDLE, the FSM SHALL not re-arm until rx_s has returned high, so a line held low after a framing error re-triggers only on a fresh falling edge.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, synchronizer flops 1, counters 0, shift 0, rx_data 8'h00, rdy 0, go 0, stop 0, frm_err 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte with no pulse; the first complete frame after release SHALL be received correctly.

Verification
REQ-028 Frame 8'h47 at BAUD_DIV=2604 -> rdy=1 and rx_data=8'h47 at 24,741±1 clocks after the start edge, go high exactly 1 clock, stop=0.
REQ-029 Frame 8'h53 -> stop pulses 1 clock, go=0; clr_rdy then asserted -> rdy=0 on the next clock while rx_data holds 8'h53.
REQ-030 Frame 8'hA5 -> rx_data=8'hA5, rdy=1, go=0, stop=0 throughout.
REQ-031 Frame 8'h47 with stop bit driven 0 -> frm_err 1-clock pulse, rdy stays 0, go=0, rx_data unchanged from the previous value.
REQ-032 RX pulsed low for 500 clocks then high -> FSM returns to IDLE after the START sample, no rdy/go/stop/frm_err activity.
REQ-033 rst_n pulsed low after 4 data bits of 8'h47 -> all outputs 0; a following full 8'h53 frame -> stop pulse, rx_data=8'h53.
